// File: rtl/wide_add_pkg.sv
// Shared types and constants for the wide add sequencer.
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wide_state_t;

    // 8-bit ALU opcodes used by the sequencer.
    localparam logic [2:0] ALU_UADD = 3'b000;
    localparam logic [2:0] ALU_SADD = 3'b101;

endpackage

// File: rtl/wide_add_seq.sv
// wide_add_seq: NBYTES-wide add built from an external 8-bit ALU,
// one byte per cycle, least-significant byte first. The ALU overflow
// output is chained back as the carry into the next byte.
// Optional macro WIDE_ADD_SUB_EN adds a Sub input for A - B.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Start,
    input  logic                  Signed_op,
`ifdef WIDE_ADD_SUB_EN
    input  logic                  Sub,
`endif
    input  logic [8*NBYTES-1:0]   OpA,
    input  logic [8*NBYTES-1:0]   OpB,
    output logic                  Busy,
    output logic                  Done,
    output logic [8*NBYTES-1:0]   Result,
    output logic                  Carry_out,
    output logic                  Ovf_out,
    output logic [7:0]            Alu_DatA,
    output logic [7:0]            Alu_DatB,
    output logic [2:0]            Alu_op,
    output logic                  Alu_CarryIn,
    input  logic [7:0]            Alu_Rslt,
    input  logic                  Alu_Overflow
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    wide_state_t   state_q,  state_d;
    logic [IW-1:0] idx_q,    idx_d;
    logic [W-1:0]  a_q,      a_d;
    logic [W-1:0]  b_q,      b_d;
    logic [W-1:0]  result_q, result_d;
    logic          signed_q, signed_d;
    logic          carry_q,  carry_d;
    logic          cout_q,   cout_d;
    logic          ovf_q,    ovf_d;

    // Subtract mode: invert B and seed the carry chain with 1.
    logic          sub_q;
    logic          start_sub;
    logic          accept;

    assign accept = Start && (state_q != RUN);

`ifdef WIDE_ADD_SUB_EN
    logic sub_d;
    assign start_sub = Sub;

    // Subtract-mode select, captured with the operands.
    always_comb begin
        sub_d = sub_q;
        if (accept) begin
            sub_d = Sub;
        end
    end

    // Subtract-mode register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sub_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
        end
    end
`else
    assign start_sub = 1'b0;
    assign sub_q     = 1'b0;
`endif

    logic [7:0] a_byte;
    logic [7:0] b_byte;

    assign a_byte = a_q[idx_q*8 +: 8];
    assign b_byte = b_q[idx_q*8 +: 8];

    // ALU drive: current byte while running, all zero otherwise.
    always_comb begin
        Alu_DatA    = 8'h00;
        Alu_DatB    = 8'h00;
        Alu_op      = ALU_UADD;
        Alu_CarryIn = 1'b0;
        if (state_q == RUN) begin
            Alu_DatA    = a_byte;
            Alu_DatB    = sub_q ? ~b_byte : b_byte;
            Alu_CarryIn = carry_q;
            // Only the top byte uses the signed opcode so the ALU
            // reports two's-complement overflow for the whole word.
            if ((idx_q == LAST) && signed_q) begin
                Alu_op = ALU_SADD;
            end
        end
    end

    // Next-state, operand latching, byte write-back and flag capture.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        signed_d = signed_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d  = RUN;
                    a_d      = OpA;
                    b_d      = OpB;
                    signed_d = Signed_op;
                    idx_d    = '0;
                    carry_d  = start_sub;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                result_d[idx_q*8 +: 8] = Alu_Rslt;
                carry_d                = Alu_Overflow;
                if (idx_q == LAST) begin
                    // Index holds at the top byte; the FSM leaves RUN.
                    state_d = DONE;
                    ovf_d   = Alu_Overflow;
                    cout_d  = signed_q ? 1'b0 : Alu_Overflow;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            signed_q <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            signed_q <= signed_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign Busy      = (state_q == RUN);
    assign Done      = (state_q == DONE);
    assign Result    = result_q;
    assign Carry_out = cout_q;
    assign Ovf_out   = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Testbench for wide_add_seq with a behavioural 8-bit ALU alongside.
// Expected results come from full-width arithmetic on the operands.
module tb_wide_add_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          Start = 1'b0;
    logic          Signed_op = 1'b0;
`ifdef WIDE_ADD_SUB_EN
    logic          Sub = 1'b0;
`endif
    logic [W-1:0]  OpA = '0;
    logic [W-1:0]  OpB = '0;
    logic          Busy;
    logic          Done;
    logic [W-1:0]  Result;
    logic          Carry_out;
    logic          Ovf_out;
    logic [7:0]    Alu_DatA;
    logic [7:0]    Alu_DatB;
    logic [2:0]    Alu_op;
    logic          Alu_CarryIn;
    logic [7:0]    Alu_Rslt;
    logic          Alu_Overflow;

    wide_add_seq #(.NBYTES(NB)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Start        (Start),
        .Signed_op    (Signed_op),
`ifdef WIDE_ADD_SUB_EN
        .Sub          (Sub),
`endif
        .OpA          (OpA),
        .OpB          (OpB),
        .Busy         (Busy),
        .Done         (Done),
        .Result       (Result),
        .Carry_out    (Carry_out),
        .Ovf_out      (Ovf_out),
        .Alu_DatA     (Alu_DatA),
        .Alu_DatB     (Alu_DatB),
        .Alu_op       (Alu_op),
        .Alu_CarryIn  (Alu_CarryIn),
        .Alu_Rslt     (Alu_Rslt),
        .Alu_Overflow (Alu_Overflow)
    );

    always #5 Clk = ~Clk;

    // Behavioural 8-bit ALU: opcode 000 reports unsigned carry,
    // opcode 101 reports signed overflow.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum  = {1'b0, Alu_DatA} + {1'b0, Alu_DatB} + {8'b0, Alu_CarryIn};
        Alu_Rslt = alu_sum[7:0];
        if (Alu_op == 3'b101) begin
            Alu_Overflow = (Alu_DatA[7] == Alu_DatB[7]) && (alu_sum[7] != Alu_DatA[7]);
        end else begin
            Alu_Overflow = alu_sum[8];
        end
    end

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: whole-word arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic sb);
        exp_t       e;
        logic [W:0] full;
        logic       ucarry;
        logic       sovf;
        if (sb) begin
            full   = {1'b0, a} - {1'b0, b};
            ucarry = (a >= b);
            sovf   = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        end else begin
            full   = {1'b0, a} + {1'b0, b};
            ucarry = full[W];
            sovf   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        end
        e.res  = full[W-1:0];
        e.cout = s ? 1'b0 : ucarry;
        e.ovf  = s ? sovf : ucarry;
        return e;
    endfunction

    // Monitor: every Done pulse must match the oldest expectation.
    always @(negedge Clk) begin
        if (Rst_n && Done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: Done high with no pending op, Result %0h at %0t",
                         Result, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", Result, e.res);
                check("carry_out", Carry_out, e.cout);
                check("ovf_out", Ovf_out, e.ovf);
                check("alu_idle_data", {Alu_DatA, Alu_DatB, Alu_CarryIn}, 0);
                $display("op done: Result %h Carry_out %b Ovf_out %b", Result, Carry_out, Ovf_out);
            end
        end
    end

    // Issue one operation starting at a negedge with the DUT not running.
    // Returns at the negedge where Done is high (or after a timeout).
    // glitch = 1 pulses Start with other operands in the middle of RUN.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic sb, input bit glitch);
        int cyc;
        Start     = 1'b1;
        OpA       = a;
        OpB       = b;
        Signed_op = s;
`ifdef WIDE_ADD_SUB_EN
        Sub       = sb;
`endif
        exp_q.push_back(model(a, b, s, sb));
        $display("issue: A %h B %h signed %b sub %b glitch %0d", a, b, s, sb, glitch);
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        OpA   = $urandom;
        OpB   = $urandom;
        cyc   = 1;
        check("busy_cycle1", Busy, 1);
        while (!Done && cyc < 20) begin
            if (glitch && cyc == 2) begin
                Start     = 1'b1;
                OpA       = ~a;
                OpB       = a ^ b;
                Signed_op = ~s;
            end else begin
                Start = 1'b0;
            end
            @(negedge Clk);
            cyc++;
        end
        Start = 1'b0;
        check("latency", cyc, NB + 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int done_cnt;
        logic sb;
        // Reset state.
        Rst_n = 1'b0;
        #12;
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_result", Result, 0);
        check("rst_flags", {Carry_out, Ovf_out}, 0);
        check("rst_alu", {Alu_DatA, Alu_DatB, Alu_op, Alu_CarryIn}, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Directed cases.
        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        run_op(32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0);
        // Start during RUN is ignored.
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b1);
`ifdef WIDE_ADD_SUB_EN
        run_op(32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b0);
        run_op(32'h00000007, 32'h00000005, 1'b0, 1'b1, 1'b0);
        run_op(32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b0);
`endif

        // Randomized, with random idle gaps (gap 0 = back-to-back from DONE).
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge Clk);
`ifdef WIDE_ADD_SUB_EN
            sb = 1'($urandom_range(0, 1));
`else
            sb = 1'b0;
`endif
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), sb, 1'($urandom_range(0, 1)));
        end

        // Reset in cycle 2 of an operation: abort with no Done.
        @(negedge Clk);
        @(negedge Clk);
        Start     = 1'b1;
        OpA       = 32'h11223344;
        OpB       = 32'h01010101;
        Signed_op = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        check("abort_result", Result, 0);
        check("abort_flags", {Carry_out, Ovf_out}, 0);
        repeat (2) @(negedge Clk);
        Rst_n    = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            if (Done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", Busy, 0);

        repeat (3) @(negedge Clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wide_add_seq.md
Name: wide_add_seq

Overview:
- Multi-cycle sequencer that performs NBYTES-wide add (signed or unsigned) using the 8-bit ALU one byte per cycle, least-significant byte first.
- Sits directly upstream and downstream of the ALU:
  - drives DatA, DatB, Alu_op and CarryIn;
  - consumes Rslt and Overflow, chaining Overflow back as the carry into the next byte.
- Used by the datapath for 16/32-bit arithmetic on the 8-bit core.

Parameters:
- NBYTES, 4, operand width in bytes; legal range 2..8.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request; sampled only when the block is not in RUN.
- Signed_op  input  1  1 = signed add (top byte uses signed ALU op), 0 = unsigned.
- OpA  input  8*NBYTES  operand A; latched on accepted Start.
- OpB  input  8*NBYTES  operand B; latched on accepted Start.
- Busy  output  1  high while in RUN.
- Done  output  1  one-cycle pulse; Result and flags valid.
- Result  output  8*NBYTES  sum; held until the next accepted Start.
- Carry_out  output  1  unsigned carry out of the top byte.
- Ovf_out  output  1  overflow flag for the selected mode.
- Alu_DatA  output  8  to ALU DatA.
- Alu_DatB  output  8  to ALU DatB.
- Alu_op  output  3  to ALU Alu_op.
- Alu_CarryIn  output  1  to ALU CarryIn.
- Alu_Rslt  input  8  from ALU Rslt.
- Alu_Overflow  input  1  from ALU Overflow.

Behaviour:
- Clock and reset: one clock Clk; Rst_n asynchronous, active-low. While low:
  - state = IDLE, byte index = 0, carry reg = 0;
  - Busy, Done, Carry_out, Ovf_out = 0; Result = 0;
  - operand latches cleared.
- States: IDLE, RUN, DONE.
- IDLE / DONE:
  - Start = 1 latches OpA, OpB and Signed_op, clears index and carry reg, and moves to RUN.
  - DONE lasts exactly one cycle (Done = 1), then goes to IDLE unless Start is accepted.
- RUN, byte index i = 0..NBYTES-1, one byte per cycle, combinational ALU drive:
  - Alu_DatA = A[8i+7:8i], Alu_DatB = B[8i+7:8i], Alu_CarryIn = carry reg.
  - Alu_op = 3'b000 for i < NBYTES-1. For i = NBYTES-1: 3'b101 if signed, 3'b000 if unsigned.
  - At the clock edge: Result byte i <= Alu_Rslt, carry reg <= Alu_Overflow, i <= i+1.
  - After i = NBYTES-1: go to DONE.
- Flag capture on the last byte:
  - Unsigned: Carry_out = Alu_Overflow, Ovf_out = Alu_Overflow.
  - Signed: Ovf_out = Alu_Overflow (ALU signed overflow); Carry_out = 0.
- Outside RUN: Alu_DatA = 0, Alu_DatB = 0, Alu_op = 3'b000, Alu_CarryIn = 0.
- Latency: Start accepted at edge 0 → RUN occupies cycles 1..NBYTES → Done high in cycle NBYTES+1. Back-to-back issue is allowed via Start in DONE.
- Start while in RUN: ignored; the operation is not disturbed.
- Input stability: OpA/OpB changes after acceptance have no effect.
- Reset mid-operation: immediate abort to the reset values; no Done pulse.
- Index wrap: not possible; the index saturates at NBYTES-1 and the FSM leaves RUN.

Optional Feature:
- Macro: WIDE_ADD_SUB_EN.
- Defined:
  - Adds input port Sub (1 bit), latched with Start.
  - When Sub = 1: Alu_DatB = ~B byte and the initial carry reg = 1, producing A - B.
  - Carry_out = 1 means no borrow (unsigned); Ovf_out = signed overflow of A - B.
- Undefined: no Sub port; add only, with initial carry 0.

Decomposition:
- Package wide_add_pkg:
  - state enum wide_state_t {IDLE, RUN, DONE};
  - ALU opcode constants ALU_UADD = 3'b000, ALU_SADD = 3'b101.
- The ALU stays an external instance; the bench instantiates alu alongside this block.
- No sub-module inside this block.

Test Plan (NBYTES = 4, bench connects the real alu):
- Unsigned 0x000000FF + 0x00000001 → Result 0x00000100, Carry_out 0, Ovf_out 0, Done exactly 5 cycles after the Start edge.
- Unsigned 0xFFFFFFFF + 0x00000001 → Result 0x00000000, Carry_out 1, Ovf_out 1.
- Signed 0x7FFFFFFF + 0x00000001 → Result 0x80000000, Ovf_out 1, Carry_out 0.
- Signed 0xFFFFFFFF + 0xFFFFFFFF → Result 0xFFFFFFFE, Ovf_out 0.
- Control corner cases:
  - Start pulsed during RUN with different operands → ignored; first result intact.
  - Rst_n low in cycle 2 → Busy 0, Result 0, no Done.
- With WIDE_ADD_SUB_EN defined: unsigned 0x00000005 - 0x00000007 → Result 0xFFFFFFFE, Carry_out 0; 0x00000007 - 0x00000005 → 0x00000002, Carry_out 1.
